// File: rtl/stopwatch_ctrl_1h.sv
// Sequencing controller for an MM:SS BCD up-counter: turns start/stop and lap/reset
// pulses into a prescaled count enable, a counter clear, a lap freeze and a 59:59 halt.
module stopwatch_ctrl_1h #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int STOP_AT_MAX = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic [3:0] value0,
   input  logic [3:0] value1,
   input  logic [3:0] value2,
   input  logic [3:0] value3,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic [3:0] disp0,
   output logic [3:0] disp1,
   output logic [3:0] disp2,
   output logic [3:0] disp3,
   output logic [1:0] state,
   output logic       done
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam bit            HALT_EN = (STOP_AT_MAX != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   state_t        st_q;
   state_t        st_d;
   logic [PW-1:0] pre_q;
   logic [3:0]    snap0_q;
   logic [3:0]    snap1_q;
   logic [3:0]    snap2_q;
   logic [3:0]    snap3_q;
   logic          running;
   logic          tick;
   logic          at_max;
   logic          halt;
   logic          snap_load;
   logic          clr_d;

   assign running = (st_q == RUN) || (st_q == LAP);
   assign tick    = running && (pre_q == PRE_MAX);
   assign at_max  = (value3 == 4'd5) && (value2 == 4'd9) &&
                    (value1 == 4'd5) && (value0 == 4'd9);
   // The halt overrides both buttons and drops any lap freeze by leaving LAP.
   assign halt    = HALT_EN && at_max && tick;

   always_comb begin
      st_d      = st_q;
      snap_load = 1'b0;
      clr_d     = 1'b0;
      if (halt) begin
         st_d = PAUSE;
      end else begin
         case (st_q)
            IDLE: begin
               if (btn_ss) st_d = RUN;
            end
            RUN: begin
               if (btn_ss) begin
                  st_d = PAUSE;
               end else if (btn_lap) begin
                  st_d      = LAP;
                  snap_load = 1'b1;
               end
            end
            LAP: begin
               if (btn_ss)       st_d = PAUSE;
               else if (btn_lap) st_d = RUN;
            end
            PAUSE: begin
               if (btn_ss) begin
                  st_d = RUN;
               end else if (btn_lap) begin
                  st_d  = IDLE;
                  clr_d = 1'b1;
               end
            end
            default: st_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= IDLE;
         pre_q   <= '0;
         cnt_en  <= 1'b0;
         done    <= 1'b0;
         cnt_clr <= 1'b1;
         snap0_q <= '0;
         snap1_q <= '0;
         snap2_q <= '0;
         snap3_q <= '0;
      end else begin
         st_q    <= st_d;
         cnt_en  <= tick && !halt;
         done    <= halt;
         cnt_clr <= clr_d;
         // PAUSE keeps the partial second so a resume finishes it.
         if (st_q == IDLE) begin
            pre_q <= '0;
         end else if (running) begin
            pre_q <= (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
         end
         if (snap_load) begin
            snap0_q <= value0;
            snap1_q <= value1;
            snap2_q <= value2;
            snap3_q <= value3;
         end
      end
   end

   assign state = st_q;
   assign disp0 = (st_q == LAP) ? snap0_q : value0;
   assign disp1 = (st_q == LAP) ? snap1_q : value1;
   assign disp2 = (st_q == LAP) ? snap2_q : value2;
   assign disp3 = (st_q == LAP) ? snap3_q : value3;

endmodule

// File: tb/tb_stopwatch_ctrl_1h.sv
// Bench for stopwatch_ctrl_1h: BCD counter models, a queue of expected output events
// popped by a monitor, and a second instance for the wrap-at-59:59 behaviour.
module tb_stopwatch_ctrl_1h;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        btn_ss, btn_lap, btn_ss_w, btn_lap_w;
   logic        cnt_en, cnt_clr, done, cnt_en_w, cnt_clr_w, done_w;
   logic [3:0]  d0, d1, d2, d3, w0, w1, w2, w3;
   logic [1:0]  state, state_w;
   logic [15:0] mv = '0;
   logic [15:0] mw = '0;
   logic [15:0] pl_val, pl_val_w;
   logic        pl_req, pl_req_w;
   logic [15:0] disp, disp_w;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        mon_en = 1'b0;
   logic [1:0]  prev_st = 2'b00;

   typedef struct packed {
      logic [31:0] cyc;
      logic [1:0]  st;
      logic        en;
      logic        dn;
      logic        clr;
   } ev_t;
   ev_t exp_q[$];

   assign disp   = {d3, d2, d1, d0};
   assign disp_w = {w3, w2, w1, w0};

   stopwatch_ctrl_1h #(.TICK_DIV(4), .STOP_AT_MAX(1)) dut (
      .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
      .value0(mv[3:0]), .value1(mv[7:4]), .value2(mv[11:8]), .value3(mv[15:12]),
      .cnt_en(cnt_en), .cnt_clr(cnt_clr),
      .disp0(d0), .disp1(d1), .disp2(d2), .disp3(d3),
      .state(state), .done(done)
   );

   stopwatch_ctrl_1h #(.TICK_DIV(4), .STOP_AT_MAX(0)) dut_w (
      .clk(clk), .rst(rst), .btn_ss(btn_ss_w), .btn_lap(btn_lap_w),
      .value0(mw[3:0]), .value1(mw[7:4]), .value2(mw[11:8]), .value3(mw[15:12]),
      .cnt_en(cnt_en_w), .cnt_clr(cnt_clr_w),
      .disp0(w0), .disp1(w1), .disp2(w2), .disp3(w3),
      .state(state_w), .done(done_w)
   );

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [3:0] a0, a1, a2, a3;
      {a3, a2, a1, a0} = v;
      if (a0 != 4'd9) a0 = a0 + 4'd1;
      else begin
         a0 = 4'd0;
         if (a1 != 4'd5) a1 = a1 + 4'd1;
         else begin
            a1 = 4'd0;
            if (a2 != 4'd9) a2 = a2 + 4'd1;
            else begin
               a2 = 4'd0;
               a3 = (a3 != 4'd5) ? a3 + 4'd1 : 4'd0;
            end
         end
      end
      return {a3, a2, a1, a0};
   endfunction

   // Counter chain models: synchronous clear from cnt_clr, preload, increment on cnt_en.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cnt_clr)     mv <= '0;
      else if (pl_req) mv <= pl_val;
      else if (cnt_en) mv <= bcd_inc(mv);
      if (cnt_clr_w)     mw <= '0;
      else if (pl_req_w) mw <= pl_val_w;
      else if (cnt_en_w) mw <= bcd_inc(mw);
   end

   // Monitor: any pulse or state change on the main instance must match the next expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cnt_en || done || cnt_clr || (state != prev_st)) begin
            n_chk = n_chk + 1;
            if (exp_q.size() == 0) begin
               n_fail = n_fail + 1;
               $display("FAIL event_unexpected: cyc=%0d st=%0d en=%0b done=%0b clr=%0b, none expected",
                        cyc, state, cnt_en, done, cnt_clr);
            end else begin
               ev_t e;
               ev_t a;
               e = exp_q.pop_front();
               a = '{cyc: cyc, st: state, en: cnt_en, dn: done, clr: cnt_clr};
               if (a != e) begin
                  n_fail = n_fail + 1;
                  $display("FAIL event: got cyc=%0d st=%0d en=%0b done=%0b clr=%0b, want cyc=%0d st=%0d en=%0b done=%0b clr=%0b",
                           a.cyc, a.st, a.en, a.dn, a.clr, e.cyc, e.st, e.en, e.dn, e.clr);
               end
            end
         end
         prev_st = state;
      end
   end

   task automatic push(input int c, input logic [1:0] st, input logic en, input logic dn,
                       input logic clr);
      exp_q.push_back('{cyc: c, st: st, en: en, dn: dn, clr: clr});
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic press(input logic ss, input logic lap);
      btn_ss  = ss;
      btn_lap = lap;
      @(negedge clk);
      btn_ss  = 1'b0;
      btn_lap = 1'b0;
   endtask

   task automatic preload(input logic [15:0] v);
      pl_val = v;
      pl_req = 1'b1;
      @(negedge clk);
      pl_req = 1'b0;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst = 1'b1;
      btn_ss = 1'b0; btn_lap = 1'b0; btn_ss_w = 1'b0; btn_lap_w = 1'b0;
      pl_req = 1'b0; pl_req_w = 1'b0; pl_val = '0; pl_val_w = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", state, 2'b00);
      chk("rst_cnt_en", cnt_en, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_cnt_clr", cnt_clr, 1'b1);
      chk("rst_disp", disp, 16'h0000);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_cnt_clr", cnt_clr, 1'b0);
      chk("rel_cnt_clr_w", cnt_clr_w, 1'b0);
      prev_st = 2'b00;
      mon_en  = 1'b1;

      // Start from IDLE: ticks every 4 cycles, first visible 5 cycles after the press.
      b = cyc;
      push(b + 1, 2'b01, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 7; k++) push(b + 1 + 4 * k, 2'b01, 1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0);
      wait_to(b + 30);
      chk("run_7_ticks_disp", disp, 16'h0007);
      wait_to(b + 31);
      push(b + 32, 2'b10, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0);

      // Resume: prescaler held at 3, so the tick comes 2 cycles into RUN.
      wait_to(b + 35);
      b = cyc;
      push(b + 1, 2'b01, 1'b0, 1'b0, 1'b0);
      push(b + 2, 2'b01, 1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0);

      // Lap at 00:08: display freezes while the counter keeps going.
      wait_to(b + 3);
      b = cyc;
      chk("pre_lap_disp", disp, 16'h0008);
      push(b + 1, 2'b11, 1'b0, 1'b0, 1'b0);
      push(b + 3, 2'b11, 1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1);
      wait_to(b + 4);
      chk("lap_frozen_disp", disp, 16'h0008);
      chk("lap_live_value", mv, 16'h0009);
      push(b + 5, 2'b01, 1'b0, 1'b0, 1'b0);
      push(b + 7, 2'b01, 1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1);
      wait_to(b + 5);
      chk("lap_exit_disp", disp, 16'h0009);

      // Both buttons together: start/stop wins.
      wait_to(b + 8);
      chk("run_disp_10", disp, 16'h0010);
      b = cyc;
      push(b + 1, 2'b10, 1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b1);
      wait_to(b + 1);
      chk("prio_disp_live", disp, 16'h0010);

      // Lap in PAUSE clears the counter and returns to IDLE.
      wait_to(b + 3);
      b = cyc;
      push(b + 1, 2'b00, 1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1);
      wait_to(b + 2);
      chk("clear_disp", disp, 16'h0000);

      // Halt at 59:59 from RUN.
      wait_to(b + 3);
      preload(16'h5958);
      b = cyc;
      push(b + 1, 2'b01, 1'b0, 1'b0, 1'b0);
      push(b + 5, 2'b01, 1'b1, 1'b0, 1'b0);
      push(b + 9, 2'b10, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0);
      wait_to(b + 6);
      chk("halt_run_5959", disp, 16'h5959);
      wait_to(b + 10);
      chk("halt_run_hold", disp, 16'h5959);
      chk("halt_run_state", state, 2'b10);

      // Halt at 59:59 from LAP: display returns to live.
      wait_to(b + 11);
      b = cyc;
      push(b + 1, 2'b00, 1'b0, 1'b0, 1'b1);
      press(1'b0, 1'b1);
      wait_to(b + 2);
      preload(16'h5958);
      b = cyc;
      push(b + 1, 2'b01, 1'b0, 1'b0, 1'b0);
      push(b + 3, 2'b11, 1'b0, 1'b0, 1'b0);
      push(b + 5, 2'b11, 1'b1, 1'b0, 1'b0);
      push(b + 9, 2'b10, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0);
      wait_to(b + 2);
      press(1'b0, 1'b1);
      wait_to(b + 6);
      chk("halt_lap_frozen", disp, 16'h5958);
      chk("halt_lap_live", mv, 16'h5959);
      wait_to(b + 10);
      chk("halt_lap_disp_live", disp, 16'h5959);
      chk("halt_lap_state", state, 2'b10);

      // Wrap instance: 59:59 ticks over to 00:00 and keeps running.
      pl_val_w = 16'h5959;
      pl_req_w = 1'b1;
      @(negedge clk);
      pl_req_w = 1'b0;
      b = cyc;
      btn_ss_w = 1'b1;
      @(negedge clk);
      btn_ss_w = 1'b0;
      wait_to(b + 5);
      chk("wrap_cnt_en", cnt_en_w, 1'b1);
      chk("wrap_state_tick", state_w, 2'b01);
      chk("wrap_done_tick", done_w, 1'b0);
      wait_to(b + 6);
      chk("wrap_disp", disp_w, 16'h0000);
      chk("wrap_state_after", state_w, 2'b01);
      chk("wrap_done_after", done_w, 1'b0);
      chk("wrap_cnt_en_after", cnt_en_w, 1'b0);

      repeat (6) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
